// File: rtl/shift_sright_arbiter.sv
// Round-robin arbiter sharing one arithmetic right barrel shifter among NPorts requesters.
// Optional SHIFT_SRIGHT_ARB_LOGICAL_EN adds a per-request logical (zero-fill) mode via req_lgc.

module shift_sright_barrel #(
    parameter int Bits   = 64,
    parameter int ShBits = 6
) (
    input  logic [Bits-1:0]   a,
    input  logic [ShBits-1:0] sh,
    input  logic              fill,
    output logic [Bits-1:0]   y
);
    logic [ShBits:0][Bits-1:0] stg;

    assign stg[0] = a;

    // Stage s conditionally shifts by 2**s, injecting the fill bit at the top.
    for (genvar s = 0; s < ShBits; s++) begin : g_stage
        localparam int D = 1 << s;
        assign stg[s+1] = sh[s] ? {{D{fill}}, stg[s][Bits-1:D]} : stg[s];
    end

    assign y = stg[ShBits];
endmodule

module shift_sright_arbiter #(
    parameter int Bits   = 64,
    parameter int NPorts = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NPorts-1:0]                 req_valid,
    output logic [NPorts-1:0]                 req_retry,
    input  logic [NPorts*Bits-1:0]            req_a,
    input  logic [NPorts*$clog2(Bits)-1:0]    req_sh,
`ifdef SHIFT_SRIGHT_ARB_LOGICAL_EN
    input  logic [NPorts-1:0]                 req_lgc,
`endif
    output logic                              res_valid,
    input  logic                              res_retry,
    output logic [Bits-1:0]                   res_b,
    output logic [$clog2(NPorts)-1:0]         res_id
);
    localparam int ShBits = $clog2(Bits);
    localparam int IdBits = $clog2(NPorts);

    logic [NPorts-1:0][Bits-1:0]   a_arr;
    logic [NPorts-1:0][ShBits-1:0] sh_arr;

    for (genvar p = 0; p < NPorts; p++) begin : g_unpack
        assign a_arr[p]  = req_a[p*Bits +: Bits];
        assign sh_arr[p] = req_sh[p*ShBits +: ShBits];
    end

    logic              res_valid_q, res_valid_d;
    logic [Bits-1:0]   res_b_q, res_b_d;
    logic [IdBits-1:0] res_id_q, res_id_d;
    logic [IdBits-1:0] ptr_q, ptr_d;

    logic              free;
    logic              grant_any;
    logic [IdBits-1:0] grant_idx;
    logic [IdBits-1:0] scan_idx;
    logic [NPorts-1:0] grant;

    assign free = !res_valid_q || !res_retry;

    // Scan from the pointer; power-of-two NPorts lets the index wrap for free.
    // Gating with reset keeps req_retry all-ones while reset is held.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (free && !reset) begin
            for (int k = 0; k < NPorts; k++) begin
                scan_idx = ptr_q + IdBits'(k);
                if (!grant_any && req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    assign req_retry = ~grant;

    logic [Bits-1:0]   sel_a;
    logic [ShBits-1:0] sel_sh;
    logic              sel_lgc;
    logic              fill;
    logic [Bits-1:0]   shifted;

    assign sel_a  = a_arr[grant_idx];
    assign sel_sh = sh_arr[grant_idx];
`ifdef SHIFT_SRIGHT_ARB_LOGICAL_EN
    assign sel_lgc = req_lgc[grant_idx];
`else
    assign sel_lgc = 1'b0;
`endif
    assign fill = sel_a[Bits-1] & ~sel_lgc;

    shift_sright_barrel #(
        .Bits   (Bits),
        .ShBits (ShBits)
    ) u_shift (
        .a    (sel_a),
        .sh   (sel_sh),
        .fill (fill),
        .y    (shifted)
    );

    always_comb begin
        res_valid_d = res_valid_q;
        res_b_d     = res_b_q;
        res_id_d    = res_id_q;
        ptr_d       = ptr_q;
        if (grant_any) begin
            res_valid_d = 1'b1;
            res_b_d     = shifted;
            res_id_d    = grant_idx;
            ptr_d       = grant_idx + 1'b1;
        end else if (free) begin
            // Slot drains; data and id keep their last values.
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_b_q     <= '0;
            res_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_b_q     <= res_b_d;
            res_id_q    <= res_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_b     = res_b_q;
    assign res_id    = res_id_q;
endmodule

// File: tb/tb_shift_sright_arbiter.sv
// Directed bench for shift_sright_arbiter at Bits=64, NPorts=4.
module tb_shift_sright_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_retry;
    logic [255:0] req_a;
    logic [23:0] req_sh;
`ifdef SHIFT_SRIGHT_ARB_LOGICAL_EN
    logic [3:0]  req_lgc;
`endif
    logic        res_valid;
    logic        res_retry;
    logic [63:0] res_b;
    logic [1:0]  res_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sright_arbiter #(.Bits(64), .NPorts(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_retry (req_retry),
        .req_a     (req_a),
        .req_sh    (req_sh),
`ifdef SHIFT_SRIGHT_ARB_LOGICAL_EN
        .req_lgc   (req_lgc),
`endif
        .res_valid (res_valid),
        .res_retry (res_retry),
        .res_b     (res_b),
        .res_id    (res_id)
    );

    task automatic set_port(input int p, input logic [63:0] a, input logic [5:0] sh);
        req_a[p*64 +: 64] = a;
        req_sh[p*6 +: 6]  = sh;
        req_valid[p]      = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        res_retry = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_sh    = '0;
        res_retry = 1'b0;
`ifdef SHIFT_SRIGHT_ARB_LOGICAL_EN
        req_lgc   = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        checks++; if (res_b !== 64'd0) begin errors++; $display("FAIL reset_b: got %h want 0", res_b); end
        checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", res_id); end
        checks++; if (req_retry !== 4'b1111) begin errors++; $display("FAIL reset_retry: got %b want 1111", req_retry); end
        req_valid = '0;
        reset     = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_port(2, 64'h8000_0000_0000_0000, 6'd4);
        #1;
        checks++; if (req_retry !== 4'b1011) begin errors++; $display("FAIL single_retry: got %b want 1011", req_retry); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", res_valid); end
        checks++; if (res_b !== 64'hF800_0000_0000_0000) begin errors++; $display("FAIL single_b: got %h want f800000000000000", res_b); end
        checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", res_id); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", res_valid); end
        checks++; if (res_b !== 64'hF800_0000_0000_0000) begin errors++; $display("FAIL single_hold_b: got %h want f800000000000000", res_b); end
    endtask

    task automatic test_boundaries();
        logic [63:0] va [4];
        logic [5:0]  vs [4];
        logic [63:0] ve [4];
        va[0] = 64'h0000_0000_0000_0100; vs[0] = 6'd8;  ve[0] = 64'h1;
        va[1] = 64'hFFFF_FFFF_FFFF_FF00; vs[1] = 6'd63; ve[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        va[2] = 64'h1234_5678_9ABC_DEF0; vs[2] = 6'd0;  ve[2] = 64'h1234_5678_9ABC_DEF0;
        va[3] = 64'h7FFF_FFFF_FFFF_FFFF; vs[3] = 6'd63; ve[3] = 64'h0;
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            set_port(0, va[v], vs[v]);
            @(negedge clk);
            req_valid = '0;
            checks++; if (res_b !== ve[v] || res_valid !== 1'b1) begin errors++; $display("FAIL boundary_%0d: got %h/%b want %h/1", v, res_b, res_valid, ve[v]); end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < 4; p++) set_port(p, 64'(p + 1) << 8, 6'd8);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (res_id !== 2'(c % 4) || res_b !== 64'(c % 4 + 1)) begin errors++; $display("FAIL rr_cycle%0d: got id %0d b %h want id %0d b %0d", c, res_id, res_b, c % 4, c % 4 + 1); end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        do_reset();
        set_port(1, 64'h8000_0000_0000_0000, 6'd4);
        @(negedge clk);
        req_valid = '0;
        res_retry = 1'b1;
        set_port(0, 64'hFFFF_FFFF_FFFF_FFF0, 6'd4);
        set_port(3, 64'h0000_0000_0000_3000, 6'd12);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_retry !== 4'b1111) begin errors++; $display("FAIL stall_retry%0d: got %b want 1111", c, req_retry); end
            checks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_b !== 64'hF800_0000_0000_0000) begin errors++; $display("FAIL stall_hold%0d: got %b/%0d/%h want 1/1/f800000000000000", c, res_valid, res_id, res_b); end
            @(negedge clk);
        end
        res_retry = 1'b0;
        #1;
        checks++; if (req_retry !== 4'b0111) begin errors++; $display("FAIL release_grant3: got %b want 0111", req_retry); end
        @(negedge clk);
        req_valid[3] = 1'b0;
        checks++; if (res_id !== 2'd3 || res_b !== 64'h3) begin errors++; $display("FAIL release_res3: got %0d/%h want 3/3", res_id, res_b); end
        #1;
        checks++; if (req_retry !== 4'b1110) begin errors++; $display("FAIL release_grant0: got %b want 1110", req_retry); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (res_id !== 2'd0 || res_b !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL release_res0: got %0d/%h want 0/ffffffffffffffff", res_id, res_b); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        set_port(2, 64'h0000_0000_0000_0F00, 6'd4);
        @(negedge clk);
        req_valid = '0;
        res_retry = 1'b1;
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd2) begin errors++; $display("FAIL areset_pre: got %b/%0d want 1/2", res_valid, res_id); end
        #2 reset = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0 || res_b !== 64'd0 || res_id !== 2'd0) begin errors++; $display("FAIL areset_clear: got %b/%h/%0d want 0/0/0", res_valid, res_b, res_id); end
        @(negedge clk);
        res_retry = 1'b0;
        reset = 1'b0;
        for (int p = 0; p < 4; p++) set_port(p, 64'h10 * 64'(p + 1), 6'd4);
        #1;
        checks++; if (req_retry !== 4'b1110) begin errors++; $display("FAIL areset_grant: got %b want 1110", req_retry); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (res_id !== 2'd0 || res_b !== 64'h1) begin errors++; $display("FAIL areset_res: got %0d/%h want 0/1", res_id, res_b); end
        @(negedge clk);
    endtask

`ifdef SHIFT_SRIGHT_ARB_LOGICAL_EN
    task automatic test_logical();
        do_reset();
        req_lgc = 4'b0010;
        set_port(1, 64'h8000_0000_0000_0000, 6'd4);
        @(negedge clk);
        req_valid = '0;
        checks++; if (res_b !== 64'h0800_0000_0000_0000) begin errors++; $display("FAIL logical_zero_fill: got %h want 0800000000000000", res_b); end
        req_lgc = 4'b0000;
        set_port(1, 64'h8000_0000_0000_0000, 6'd4);
        @(negedge clk);
        req_valid = '0;
        checks++; if (res_b !== 64'hF800_0000_0000_0000) begin errors++; $display("FAIL logical_arith: got %h want f800000000000000", res_b); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_boundaries();
        test_round_robin();
        test_back_pressure();
        test_async_reset();
`ifdef SHIFT_SRIGHT_ARB_LOGICAL_EN
        test_logical();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
